// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions used by the stopwatch encoder and the capture decoder.
// Segment codes are the active-low patterns on seg_n[6:0] ([0]=a .. [6]=g).
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h18;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [3:0] BCD_BLANK   = 4'hF;
  localparam logic [3:0] BCD_ILLEGAL = 4'hE;

  // Frame FSM encoding, kept as plain constants for older consumers
  typedef logic [1:0] frame_state_t;
  localparam frame_state_t ST_IDLE    = 2'd0;
  localparam frame_state_t ST_COLLECT = 2'd1;
  localparam frame_state_t ST_DONE    = 2'd2;

  // Forward mapping used by the encoder; anything above 9 shows blank
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment code to BCD decoder.
// All segments off decodes to BCD_BLANK; any unknown pattern decodes to BCD_ILLEGAL.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] code,
  output logic       illegal,
  output logic       blank,
  output logic [3:0] bcd
);

  // Map a segment pattern onto its digit, flagging blank and unknown patterns
  always_comb begin
    illegal = 1'b0;
    blank   = 1'b0;
    bcd     = BCD_ILLEGAL;
    case (code)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: begin
        bcd   = BCD_BLANK;
        blank = 1'b1;
      end
      default: begin
        bcd     = BCD_ILLEGAL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Display monitor: watches the multiplexed active-low segment/anode bus, waits for
// each digit to settle, decodes it back to BCD and holds one nibble per position.
// Optional build macro: DP_CAPTURE_EN (captures the decimal point per position).
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    illegal_err,
  output logic [NUM_DIGITS-1:0]   dp
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ARM  = CW'(STABLE_CYCLES - 2);
  localparam logic [NUM_DIGITS-1:0]   ALL_ONES = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0]   ALL_ZERO = {NUM_DIGITS{1'b0}};
  localparam logic [4*NUM_DIGITS-1:0] DIG_ZERO = {(4*NUM_DIGITS){1'b0}};

  logic [7:0]            seg_meta_r, seg_sync_r, seg_prev_r;
  logic [NUM_DIGITS-1:0] an_meta_r, an_sync_r, an_prev_r;
  logic [CW-1:0]         cnt_r;

  logic                  change_s, capture_s, cap_digit_s, cap_multi_s, cap_err_s;
  logic [3:0]            lit_cnt_s;
  logic [NUM_DIGITS-1:0] sel_s;
  logic                  dec_illegal_s, dec_blank_s;
  logic [3:0]            dec_bcd_s;

  logic [4*NUM_DIGITS-1:0] digits_r;
  logic [NUM_DIGITS-1:0]   valid_r, mask_r, mask_n_s;
  logic                    err_r, frame_done_r;
  frame_state_t            state_r, state_n_s;

  // Bus synchroniser, previous-sample register and stability counter (not affected by clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta_r <= 8'hFF;
      seg_sync_r <= 8'hFF;
      seg_prev_r <= 8'hFF;
      an_meta_r  <= ALL_ONES;
      an_sync_r  <= ALL_ONES;
      an_prev_r  <= ALL_ONES;
      cnt_r      <= CNT_ZERO;
    end else begin
      seg_meta_r <= seg_n;
      seg_sync_r <= seg_meta_r;
      seg_prev_r <= seg_sync_r;
      an_meta_r  <= an_n;
      an_sync_r  <= an_meta_r;
      an_prev_r  <= an_sync_r;
      if (change_s) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign change_s = ({an_sync_r, seg_sync_r} != {an_prev_r, seg_prev_r});
  // Fires once per stable window: the cycle the counter steps onto its saturation value
  assign capture_s = !change_s && (cnt_r == CNT_ARM);
  assign sel_s     = ~an_sync_r;

  // Count lit anodes so blanked, single and multi-hot patterns can be told apart
  always_comb begin
    lit_cnt_s = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lit_cnt_s = lit_cnt_s + {3'b000, sel_s[i]};
    end
  end

  seg7_to_bcd u_dec (
    .code    (seg_sync_r[6:0]),
    .illegal (dec_illegal_s),
    .blank   (dec_blank_s),
    .bcd     (dec_bcd_s)
  );

  assign cap_digit_s = capture_s && (lit_cnt_s == 4'd1);
  assign cap_multi_s = capture_s && (lit_cnt_s > 4'd1);
  // A blank digit is a legitimate display state, never an error
  assign cap_err_s   = cap_multi_s || (cap_digit_s && dec_illegal_s && !dec_blank_s);

  // Capture decoded nibble, valid flag and sticky error; clear beats a same-cycle capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_r <= DIG_ZERO;
      valid_r  <= ALL_ZERO;
      err_r    <= 1'b0;
    end else if (clear) begin
      digits_r <= DIG_ZERO;
      valid_r  <= ALL_ZERO;
      err_r    <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (cap_digit_s && sel_s[k]) begin
          digits_r[4*k +: 4] <= dec_bcd_s;
          valid_r[k]         <= 1'b1;
        end
      end
      if (cap_err_s) begin
        err_r <= 1'b1;
      end
    end
  end

`ifdef DP_CAPTURE_EN
  logic [NUM_DIGITS-1:0] dp_r;

  // Capture the decimal point of the lit position together with its digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_r <= ALL_ZERO;
    end else if (clear) begin
      dp_r <= ALL_ZERO;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (cap_digit_s && sel_s[k]) begin
          dp_r[k] <= ~seg_sync_r[7];
        end
      end
    end
  end

  assign dp = dp_r;
`else
  assign dp = ALL_ZERO;
`endif

  // Frame FSM next state: collect positions into the mask, complete when all are seen
  always_comb begin
    state_n_s = state_r;
    mask_n_s  = mask_r;
    case (state_r)
      ST_IDLE, ST_COLLECT: begin
        if (cap_digit_s) begin
          mask_n_s  = mask_r | sel_s;
          state_n_s = (mask_n_s == ALL_ONES) ? ST_DONE : ST_COLLECT;
        end else begin
          mask_n_s  = mask_r;
          state_n_s = state_r;
        end
      end
      ST_DONE: begin
        // The completed mask is dropped; a capture landing here starts the next frame
        if (cap_digit_s) begin
          mask_n_s  = sel_s;
          state_n_s = (sel_s == ALL_ONES) ? ST_DONE : ST_COLLECT;
        end else begin
          mask_n_s  = ALL_ZERO;
          state_n_s = ST_IDLE;
        end
      end
      default: begin
        mask_n_s  = ALL_ZERO;
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // Frame FSM state, mask and the registered one-cycle frame_done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      mask_r       <= ALL_ZERO;
      frame_done_r <= 1'b0;
    end else if (clear) begin
      state_r      <= ST_IDLE;
      mask_r       <= ALL_ZERO;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      mask_r       <= mask_n_s;
      frame_done_r <= (state_n_s == ST_DONE);
    end
  end

  assign digits      = digits_r;
  assign digit_valid = valid_r;
  assign illegal_err = err_r;
  assign frame_done  = frame_done_r;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Self-checking bench for seg7_capture_decoder: directed display-bus vectors, a
// behavioural model of settle/capture/frame rules compared every cycle, plus
// hand-computed literal expectations. Honours DP_CAPTURE_EN like the design.
module tb_seg7_capture_decoder;

  localparam int ND = 4;
  localparam int S  = 16;
`ifdef DP_CAPTURE_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif
  localparam logic [7:0] CODE_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h98};

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic [7:0]      seg_n = 8'hFF;
  logic [ND-1:0]   an_n  = {ND{1'b1}};
  logic [4*ND-1:0] digits;
  logic [ND-1:0]   digit_valid, dp;
  logic            frame_done, illegal_err;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_count = 0;

  seg7_capture_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .clear       (clear),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .illegal_err (illegal_err),
    .dp          (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]    m_dig [ND];
  logic [ND-1:0] m_val, m_dp, m_mask;
  logic          m_err, m_fd;
  logic [ND+7:0] prev_in;
  int            cyc, last_chg;

  function automatic logic [3:0] model_decode(input logic [6:0] c);
    logic [7:0] t;
    if (c == 7'h7F) return 4'hF;
    for (int d = 0; d < 10; d++) begin
      t = CODE_TBL[d];
      if (c == t[6:0]) return 4'(d);
    end
    return 4'hE;
  endfunction

  task automatic model_clear_outputs();
    for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
    m_val  = '0;
    m_dp   = '0;
    m_mask = '0;
    m_err  = 1'b0;
    m_fd   = 1'b0;
  endtask

  task automatic model_capture();
    int lit;
    int k;
    logic [3:0] d;
    lit = 0;
    k   = 0;
    for (int i = 0; i < ND; i++) begin
      if (an_n[i] == 1'b0) begin
        lit++;
        k = i;
      end
    end
    if (lit > 1) begin
      m_err = 1'b1;
    end else if (lit == 1) begin
      d        = model_decode(seg_n[6:0]);
      m_dig[k] = d;
      m_val[k] = 1'b1;
      if (d == 4'hE) m_err = 1'b1;
      if (DP_EN) m_dp[k] = ~seg_n[7];
      m_mask[k] = 1'b1;
      if (m_mask == {ND{1'b1}}) begin
        m_fd   = 1'b1;
        m_mask = '0;
      end
    end
  endtask

  // Model: a bus value held unchanged is captured 2+S edges after it was driven
  initial begin
    cyc      = 0;
    last_chg = -1000;
    prev_in  = '1;
    model_clear_outputs();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear_outputs();
        prev_in  = '1;
        last_chg = -1000;
      end else begin
        cyc++;
        if ({an_n, seg_n} != prev_in) begin
          prev_in  = {an_n, seg_n};
          last_chg = cyc - 1;
        end
        m_fd = 1'b0;
        if (clear) model_clear_outputs();
        else if (cyc - last_chg == S + 2) model_capture();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    logic [4*ND-1:0] flat;
    forever begin
      @(negedge clk);
      for (int i = 0; i < ND; i++) flat[4*i +: 4] = m_dig[i];
      check("cyc_digits", 32'(digits), 32'(flat));
      check("cyc_valid", 32'(digit_valid), 32'(m_val));
      check("cyc_frame_done", 32'(frame_done), 32'(m_fd));
      check("cyc_illegal_err", 32'(illegal_err), 32'(m_err));
      check("cyc_dp", 32'(dp), 32'(m_dp));
    end
  end

  // Count frame_done pulses
  initial forever begin
    @(negedge clk);
    if (frame_done === 1'b1) fd_count++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_bus(input logic [7:0] s, input logic [ND-1:0] a);
    @(posedge clk);
    #1;
    seg_n = s;
    an_n  = a;
  endtask

  task automatic hold(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic show(input logic [7:0] s, input logic [ND-1:0] a);
    set_bus(s, a);
    hold(19);
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_digits"}, 32'(digits), 32'h0);
    check({tag, "_valid"}, 32'(digit_valid), 32'h0);
    check({tag, "_fd"}, 32'(frame_done), 32'h0);
    check({tag, "_err"}, 32'(illegal_err), 32'h0);
    check({tag, "_dp"}, 32'(dp), 32'h0);
  endtask

  initial begin
    int fd0;
    // Power-on reset
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;
    hold(30);
    check("post_reset_valid", 32'(digit_valid), 32'h0);

    // Scan 1,2,3,4 on positions 0..3
    fd0 = fd_count;
    show(8'hF9, 4'b1110);
    show(8'hA4, 4'b1101);
    show(8'hB0, 4'b1011);
    show(8'h99, 4'b0111);
    check("scan_digits", 32'(digits), 32'h4321);
    check("scan_valid", 32'(digit_valid), 32'hF);
    check("scan_err", 32'(illegal_err), 32'h0);
    check("scan_frame_pulses", 32'(fd_count - fd0), 32'd1);

    // Reset mid-stream: outputs drop immediately, nothing captured after release
    set_bus(8'h92, 4'b1110);
    hold(9);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    seg_n = 8'hFF;
    an_n  = 4'b1111;
    hold(3);
    rst_n = 1'b1;
    hold(30);
    check("release_valid", 32'(digit_valid), 32'h0);
    check("release_digits", 32'(digits), 32'h0);

    // Glitching bus: no capture while toggling, one capture 2+S after last change
    for (int i = 0; i < 20; i++) begin
      set_bus((i % 2 == 1) ? 8'hF9 : 8'hC0, 4'b1110);
      if (i < 19) hold(4);
    end
    check("glitch_no_capture", 32'(digit_valid), 32'h0);
    hold(S + 1);
    check("glitch_before_latency", 32'(digit_valid), 32'h0);
    hold(1);
    check("glitch_at_latency", 32'(digit_valid), 32'h1);
    check("glitch_digit", 32'(digits[3:0]), 32'h1);

    // Bad segment code and multi-hot anodes
    pulse_clear();
    show(8'hF6, 4'b1101);
    check("bad_code_digit", 32'(digits[7:4]), 32'hE);
    check("bad_code_err", 32'(illegal_err), 32'h1);
    show(8'hC0, 4'b1110);
    check("err_sticky", 32'(illegal_err), 32'h1);
    pulse_clear();
    check("err_cleared", 32'(illegal_err), 32'h0);
    show(8'hC0, 4'b1100);
    check("multi_hot_err", 32'(illegal_err), 32'h1);
    check("multi_hot_no_update", 32'(digit_valid), 32'h0);
    pulse_clear();

    // Blank position, then clear colliding with the frame-completing capture
    fd0 = fd_count;
    show(8'hF8, 4'b1110);
    show(8'h80, 4'b1101);
    show(8'hFF, 4'b1011);
    check("blank_digit", 32'(digits[11:8]), 32'hF);
    check("blank_no_err", 32'(illegal_err), 32'h0);
    check("blank_digits_all", 32'(digits), 32'h0F87);
    set_bus(8'hB0, 4'b0111);
    hold(S + 1);
    clear = 1'b1;
    hold(1);
    clear = 1'b0;
    check_all_zero("clear_on_capture");
    hold(10);
    check("clear_no_frame", 32'(fd_count - fd0), 32'd0);
    check("clear_no_recapture", 32'(digit_valid), 32'h0);
    show(8'h82, 4'b1110);
    show(8'h98, 4'b1101);
    show(8'hC0, 4'b1011);
    show(8'h92, 4'b0111);
    check("refill_digits", 32'(digits), 32'h5096);
    check("refill_frame", 32'(fd_count - fd0), 32'd1);

    // Decimal point capture
    pulse_clear();
    show(8'h40, 4'b1110);
    check("dp_digit", 32'(digits[3:0]), 32'h0);
    check("dp_pos0", 32'(dp[0]), 32'(DP_EN));
    show(8'hC0, 4'b1101);
    check("dp_pos1_off", 32'(dp[1]), 32'h0);
    hold(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
